// File: rtl/id_ex_ctrl_pipe_pkg.sv
// id_ex_ctrl_pipe_pkg: opcode map, ALU codes, control bundle, bubble constant and instruction field offsets
package id_ex_ctrl_pipe_pkg;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW = 4'h8, OP_SW = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB;
  localparam logic [3:0] OP_B = 4'hC, OP_BR = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF;
  localparam logic [3:0] ALU_ADD = 4'h0, ALU_PCS = 4'hE, ALU_HLT = 4'hF;
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       pc_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
  function automatic int rd_hi(int iw, int ow);
    return iw - ow - 1;
  endfunction
  function automatic int rs_hi(int iw, int ow, int rw);
    return iw - ow - rw - 1;
  endfunction
  function automatic int rt_hi(int iw, int ow, int rw);
    return iw - ow - 2 * rw - 1;
  endfunction
endpackage

// File: rtl/id_ex_ctrl_pipe_if.sv
// id_ex_ctrl_pipe_if: fetch-side handshake in, ID/EX control register and status out; master = pipe stage, slave = its environment
interface id_ex_ctrl_pipe_if #(
  parameter int INSTR_W = 16,
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic               ex_hold;
  logic               flush;
  logic               stall_if;
  logic               id_ex_valid;
  logic               RegWrite;
  logic               ALUSrc;
  logic               PCSrc;
  logic               memWrite;
  logic               memRead;
  logic               MemtoReg;
  logic [3:0]         ALU_operation;
  logic [REG_W-1:0]   id_ex_rd;
  logic [REG_W-1:0]   id_ex_rs;
  logic [REG_W-1:0]   id_ex_rt;
  logic               halted;
  logic [CNT_W-1:0]   stall_cnt;
  modport master (
    input  if_valid, if_instr, ex_hold, flush,
    output stall_if, id_ex_valid, RegWrite, ALUSrc, PCSrc, memWrite, memRead, MemtoReg,
           ALU_operation, id_ex_rd, id_ex_rs, id_ex_rt, halted, stall_cnt
  );
  modport slave (
    output if_valid, if_instr, ex_hold, flush,
    input  stall_if, id_ex_valid, RegWrite, ALUSrc, PCSrc, memWrite, memRead, MemtoReg,
           ALU_operation, id_ex_rd, id_ex_rs, id_ex_rt, halted, stall_cnt
  );
endinterface

// File: rtl/id_ex_ctrl_pipe_instr_decode.sv
// instr_decode: combinational opcode -> control bundle, source-register use flags (op in; ctrl, use_rs/rt/rd, is_hlt out)
module instr_decode
  import id_ex_ctrl_pipe_pkg::*;
(
  input  logic [3:0] op,
  output ctrl_t      ctrl,
  output logic       use_rs,
  output logic       use_rt,
  output logic       use_rd,
  output logic       is_hlt
);
  always_comb begin
    ctrl = CTRL_BUBBLE;
    ctrl.reg_write = !(op inside {OP_SW, OP_B, OP_BR, OP_HLT});
    ctrl.alu_src = op inside {OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_SW, OP_LLB, OP_LHB, OP_B, OP_BR};
    ctrl.alu_op = op inside {OP_LW, OP_SW} ? ALU_ADD : op == OP_PCS ? ALU_PCS : op == OP_HLT ? ALU_HLT : op;
    ctrl.pc_src = op inside {OP_B, OP_BR};
    ctrl.mem_write = op == OP_SW;
    ctrl.mem_read = op == OP_LW;
    ctrl.mem_to_reg = op == OP_LW;
    use_rt = op inside {OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB};
    use_rs = use_rt | (op inside {OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_SW, OP_BR});
    use_rd = op inside {OP_SW, OP_LLB, OP_LHB};
    is_hlt = op == OP_HLT;
  end
endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// id_ex_ctrl_pipe: decode stage driving the ID/EX control register with load-use stall, flush, hold and halt handling (clk, rst_n, bus)
module id_ex_ctrl_pipe
  import id_ex_ctrl_pipe_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W = 4,
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  id_ex_ctrl_pipe_if.master bus
);
  localparam int RD_HI = rd_hi(INSTR_W, OPC_W);
  localparam int RS_HI = rs_hi(INSTR_W, OPC_W, REG_W);
  localparam int RT_HI = rt_hi(INSTR_W, OPC_W, REG_W);
  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] rd, rs, rt, rd_q, rs_q, rt_q;
  logic [CNT_W-1:0] cnt_q;
  logic use_rs, use_rt, use_rd, is_hlt, hazard, kill, issue, v_q, halt_q, fp_q;
  ctrl_t dec, ctl_q;
  assign opc = bus.if_instr[INSTR_W-1 -: OPC_W];
  assign rd = bus.if_instr[RD_HI -: REG_W];
  assign rs = bus.if_instr[RS_HI -: REG_W];
  assign rt = bus.if_instr[RT_HI -: REG_W];
  instr_decode u_dec (
    .op    (4'(opc)),
    .ctrl  (dec),
    .use_rs(use_rs),
    .use_rt(use_rt),
    .use_rd(use_rd),
    .is_hlt(is_hlt)
  );
  assign hazard = bus.if_valid & v_q & ctl_q.mem_read & (|rd_q) &
                  ((use_rs & rs == rd_q) | (use_rt & rt == rd_q) | (use_rd & rd == rd_q));
  // a pending flush kills like a live one; a stall bubble is only counted when nothing outranks it
  assign kill = bus.flush | fp_q | halt_q;
  assign issue = !kill & !hazard & bus.if_valid;
  // fetch must be free to redirect on a flush even while execute holds
  assign bus.stall_if = !bus.flush & (hazard | halt_q | bus.ex_hold);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v_q, ctl_q, rd_q, rs_q, rt_q, halt_q, fp_q, cnt_q} <= '0;
    end else if (bus.ex_hold) begin
      fp_q <= fp_q | bus.flush;
    end else begin
      fp_q <= 1'b0;
      v_q <= issue;
      ctl_q <= issue ? dec : CTRL_BUBBLE;
      rd_q <= issue ? rd : '0;
      rs_q <= issue ? rs : '0;
      rt_q <= issue ? rt : '0;
      halt_q <= halt_q | (issue & is_hlt);
      if (!kill & hazard & ~&cnt_q) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign bus.id_ex_valid = v_q;
  assign bus.RegWrite = ctl_q.reg_write;
  assign bus.ALUSrc = ctl_q.alu_src;
  assign bus.ALU_operation = ctl_q.alu_op;
  assign bus.PCSrc = ctl_q.pc_src;
  assign bus.memWrite = ctl_q.mem_write;
  assign bus.memRead = ctl_q.mem_read;
  assign bus.MemtoReg = ctl_q.mem_to_reg;
  assign bus.id_ex_rd = rd_q;
  assign bus.id_ex_rs = rs_q;
  assign bus.id_ex_rt = rt_q;
  assign bus.halted = halt_q;
  assign bus.stall_cnt = cnt_q;
endmodule
